free_list_mp: RTL

Multi-port, parametrised free list of physical register tags for the rename stage. It is the successor to the two-pop / one-push free list, generalised to POP_PORTS rename lanes and PUSH_PORTS commit lanes. Depth and tag range are parametric, and it gains a single branch checkpoint that rewinds the pop pointer on mispredict. It is a circular buffer that sits between commit (tag return) and rename (tag allocation).

---
 rtl/free_list_pkg.sv | 18 +
 rtl/and_or_mux.sv | 14 +
 rtl/free_list_push_compact.sv | 21 ++
 rtl/free_list_mp.sv | 123 ++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared types and pointer helper for the multi-port rename free list.
package free_list_pkg;
  localparam int FL_DATA_WIDTH  = 7;
  localparam int FL_P_REGISTERS = 128;
  localparam int FL_L_REGISTERS = 32;
  localparam int FL_DEPTH       = FL_P_REGISTERS - FL_L_REGISTERS;

  typedef logic [FL_DATA_WIDTH-1:0]      tag_t;
  typedef logic [$clog2(FL_DEPTH)-1:0]   ptr_t;
  typedef logic [$clog2(FL_DEPTH+1)-1:0] cnt_t;

  // Modular add; operands keep a+b < 2*depth so one subtract suffices.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction
endpackage

// File: rtl/and_or_mux.sv
// One-hot select mux built as an AND-OR tree.
module and_or_mux #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] data,
  output logic [W-1:0]        out
);
  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) out = out | (data[k] & {W{sel[k]}});
  end
endmodule

// File: rtl/free_list_push_compact.sv
// Prefix popcount of the push mask: per-lane write offset and total push count.
module free_list_push_compact #(
  parameter int PUSH_PORTS = 2,
  parameter int OW         = $clog2(PUSH_PORTS+1)
) (
  input  logic [PUSH_PORTS-1:0]         push,
  output logic [PUSH_PORTS-1:0][OW-1:0] offs,
  output logic [OW-1:0]                 npush
);
  logic [OW-1:0] acc;

  always_comb begin
    acc  = '0;
    offs = '0;
    for (int j = 0; j < PUSH_PORTS; j++) begin
      offs[j] = acc;
      acc     = acc + OW'(push[j]);
    end
    npush = acc;
  end
endmodule

// File: rtl/free_list_mp.sv
// Multi-port circular free list of physical tags with optional branch checkpoint
// of the pop pointer (enable with FREE_LIST_CHECKPOINT_EN).
module free_list_mp
  import free_list_pkg::*;
#(
  parameter int DATA_WIDTH  = FL_DATA_WIDTH,
  parameter int P_REGISTERS = FL_P_REGISTERS,
  parameter int L_REGISTERS = FL_L_REGISTERS,
  parameter int DEPTH       = P_REGISTERS - L_REGISTERS,
  parameter int POP_PORTS   = 4,
  parameter int PUSH_PORTS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [PUSH_PORTS-1:0]                 push,
  input  logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] push_data,
  output logic                                  ready,
  input  logic [POP_PORTS-1:0]                  pop,
  output logic [POP_PORTS-1:0][DATA_WIDTH-1:0]  pop_data,
  output logic [POP_PORTS-1:0]                  valid,
  input  logic                                  ckpt_save,
  input  logic                                  ckpt_restore
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(PUSH_PORTS+1);
  localparam int NW = $clog2(POP_PORTS+1);

  typedef logic [PW-1:0] ptr_l;
  typedef logic [CW-1:0] cnt_l;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  ptr_l head, tail, head_adv, head_next, tail_next;
  cnt_l count, count_step, count_next;
  logic [PUSH_PORTS-1:0][OW-1:0] push_off;
  logic [PUSH_PORTS-1:0][PW-1:0] wr_idx;
  logic [OW-1:0] npush;
  logic [NW-1:0] npop;

  free_list_push_compact #(.PUSH_PORTS(PUSH_PORTS), .OW(OW)) u_compact (
    .push  (push),
    .offs  (push_off),
    .npush (npush)
  );

  always_comb begin
    npop = '0;
    for (int i = 0; i < POP_PORTS; i++) npop = npop + NW'(pop[i]);
  end

  always_comb begin
    wr_idx = '0;
    for (int j = 0; j < PUSH_PORTS; j++)
      wr_idx[j] = ptr_l'(wrap_add(32'(tail), 32'(push_off[j]), DEPTH));
  end

  assign head_adv   = ptr_l'(wrap_add(32'(head), 32'(npop), DEPTH));
  assign tail_next  = ptr_l'(wrap_add(32'(tail), 32'(npush), DEPTH));
  assign count_step = count + cnt_l'(npush) - cnt_l'(npop);

`ifdef FREE_LIST_CHECKPOINT_EN
  ptr_l ckpt_head, rewind;

  // Entries popped since the snapshot go back on the list; pops this cycle are dropped.
  assign rewind     = ptr_l'(wrap_add(32'(head), 32'(DEPTH) - 32'(ckpt_head), DEPTH));
  assign head_next  = ckpt_restore ? ckpt_head : head_adv;
  assign count_next = ckpt_restore ? count + cnt_l'(rewind) + cnt_l'(npush) : count_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ckpt_head <= '0;
    else if (ckpt_save && !ckpt_restore) ckpt_head <= head_adv;
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save ^ ckpt_restore;
  assign head_next   = head_adv;
  assign count_next  = count_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= DATA_WIDTH'(L_REGISTERS + k);
      head  <= '0;
      tail  <= '0;
      count <= cnt_l'(DEPTH);
    end else begin
      for (int j = 0; j < PUSH_PORTS; j++)
        if (push[j]) mem[wr_idx[j]] <= push_data[j];
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  for (genvar i = 0; i < POP_PORTS; i++) begin : g_pop
    ptr_l             ridx;
    logic [DEPTH-1:0] rsel;
    assign ridx     = ptr_l'(wrap_add(32'(head), i, DEPTH));
    assign rsel     = DEPTH'(1) << ridx;
    assign valid[i] = (count > cnt_l'(i));
    and_or_mux #(.N(DEPTH), .W(DATA_WIDTH)) u_mux (
      .sel  (rsel),
      .data (mem),
      .out  (pop_data[i])
    );
  end

  assign ready = (cnt_l'(DEPTH) - count) >= cnt_l'(PUSH_PORTS);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 1; i < POP_PORTS; i++)
        assert (!pop[i] || pop[i-1]) else $error("free_list_mp: pop not thermometer-coded");
      assert ((pop & ~valid) == '0) else $error("free_list_mp: pop on lane without a tag");
      assert (push == '0 || ready) else $error("free_list_mp: push while not ready");
`ifndef FREE_LIST_CHECKPOINT_EN
      assert (!ckpt_restore) else $error("free_list_mp: ckpt_restore without checkpoint support");
`endif
    end
  end
`endif
endmodule
